// File: rtl/sim_harness_ctrl_if.sv
// Halt request and status bundle between the bench and sim_harness_ctrl.
// master = bench side, slave = controller side.
interface sim_harness_ctrl_if #(
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 32
);
    logic [NUM_SRC-1:0]   halt_req;
    logic [8*NUM_SRC-1:0] halt_data;
    logic                 core_rst;
    logic                 running;
    logic [CNT_W-1:0]     cycle_cnt;
    logic                 done;
    logic                 timeout;
    logic [7:0]           exit_code;
    logic [NUM_SRC-1:0]   exit_src;

    modport master (
        output halt_req, halt_data,
        input  core_rst, running, cycle_cnt, done,
        input  timeout, exit_code, exit_src
    );

    modport slave (
        input  halt_req, halt_data,
        output core_rst, running, cycle_cnt, done,
        output timeout, exit_code, exit_src
    );
endinterface

// File: rtl/sim_harness_ctrl.sv
// Core reset sequencer, run-cycle counter, halt capture and drain for sims.
// Optional watchdog is compiled in with `define SIM_TIMEOUT_EN.
module sim_harness_ctrl #(
    parameter int          RST_CYCLES     = 25,
    parameter int          NUM_SRC        = 2,
    parameter int          CNT_W          = 32,
    parameter int          DRAIN_CYCLES   = 16,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd150_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    sim_harness_ctrl_if.slave bus
);

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        ST_RST,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t             state, state_d;
    logic [RW-1:0]      rst_cnt, rst_cnt_d;
    logic [DW-1:0]      drain_cnt, drain_cnt_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               core_rst, core_rst_d;
    logic               running, running_d;
    logic               done, done_d;
    logic [7:0]         code, code_d;
    logic [NUM_SRC-1:0] src, src_d;
    logic [NUM_SRC-1:0] hit_src;
    logic [7:0]         hit_code;

`ifdef SIM_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic timeout, timeout_d;
`endif

    // Descending scan so the lowest asserted source is assigned last.
    always_comb begin
        hit_src  = '0;
        hit_code = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (bus.halt_req[i]) begin
                hit_src    = '0;
                hit_src[i] = 1'b1;
                hit_code   = bus.halt_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state;
        rst_cnt_d   = rst_cnt;
        drain_cnt_d = drain_cnt;
        cnt_d       = cnt;
        core_rst_d  = core_rst;
        running_d   = running;
        done_d      = done;
        code_d      = code;
        src_d       = src;
`ifdef SIM_TIMEOUT_EN
        timeout_d   = timeout;
`endif
        unique case (state)
            ST_RST: begin
                if (rst_cnt == RST_LAST) begin
                    state_d    = ST_RUN;
                    core_rst_d = 1'b0;
                    running_d  = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (|bus.halt_req) begin
                    state_d   = ST_DRAIN;
                    running_d = 1'b0;
                    code_d    = hit_code;
                    src_d     = hit_src;
                end
`ifdef SIM_TIMEOUT_EN
                else if (cnt == TO_LAST) begin
                    state_d    = ST_DONE;
                    running_d  = 1'b0;
                    done_d     = 1'b1;
                    core_rst_d = 1'b1;
                    timeout_d  = 1'b1;
                    code_d     = 8'hFF;
                    src_d      = '0;
                end
`endif
                else if (cnt != '1) begin
                    cnt_d = cnt + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_d    = ST_DONE;
                    done_d     = 1'b1;
                    core_rst_d = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt + 1'b1;
                end
            end
            ST_DONE: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RST;
            rst_cnt   <= '0;
            drain_cnt <= '0;
            cnt       <= '0;
            core_rst  <= 1'b1;
            running   <= 1'b0;
            done      <= 1'b0;
            code      <= '0;
            src       <= '0;
        end else begin
            state     <= state_d;
            rst_cnt   <= rst_cnt_d;
            drain_cnt <= drain_cnt_d;
            cnt       <= cnt_d;
            core_rst  <= core_rst_d;
            running   <= running_d;
            done      <= done_d;
            code      <= code_d;
            src       <= src_d;
        end
    end

`ifdef SIM_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) timeout <= 1'b0;
        else        timeout <= timeout_d;
    end
    assign bus.timeout = timeout;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.core_rst  = core_rst;
    assign bus.running   = running;
    assign bus.cycle_cnt = cnt;
    assign bus.done      = done;
    assign bus.exit_code = code;
    assign bus.exit_src  = src;

endmodule

// File: tb/tb_sim_harness_ctrl.sv
// Randomized bench for sim_harness_ctrl against a timeline model
// derived from the halt cycle, reset length and drain length.
module tb_sim_harness_ctrl;

    localparam int R = 25;
    localparam int D = 16;
`ifdef SIM_TIMEOUT_EN
    localparam int TO = 64;
`else
    localparam int TO = 1 << 30;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sim_harness_ctrl_if #(.NUM_SRC(2), .CNT_W(32)) bus ();
    sim_harness_ctrl_if #(.NUM_SRC(2), .CNT_W(4))  bus_s ();

    sim_harness_ctrl #(
        .RST_CYCLES(R), .NUM_SRC(2), .CNT_W(32),
        .DRAIN_CYCLES(D), .TIMEOUT_CYCLES(32'd64)
    ) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    sim_harness_ctrl #(
        .RST_CYCLES(3), .NUM_SRC(2), .CNT_W(4),
        .DRAIN_CYCLES(2), .TIMEOUT_CYCLES(32'd1000)
    ) u_sat (.clk(clk), .rst_n(rst_n), .bus(bus_s));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset();
        chk("rst_core_rst", 32'(bus.core_rst), 1);
        chk("rst_running", 32'(bus.running), 0);
        chk("rst_cycle_cnt", bus.cycle_cnt, 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_timeout", 32'(bus.timeout), 0);
        chk("rst_exit_code", 32'(bus.exit_code), 0);
        chk("rst_exit_src", 32'(bus.exit_src), 0);
    endtask

    // k = run cycle in which halt_req first goes high (pattern pat)
    task automatic run_trial(input int k, input logic [1:0] pat,
                             input logic [15:0] data, input bit abort);
        int h, e, last, a, j;
        bit tmo, cap, fin, run;
        logic [1:0] src;
        logic [7:0] code;
        logic [31:0] exp_cnt;

        rst_n = 1'b0;
        bus.halt_req = '0;
        repeat (2) @(negedge clk);
        check_reset();
        bus.halt_req = 2'($urandom);
        bus.halt_data = 16'($urandom);
        @(negedge clk);
        rst_n = 1'b1;

        tmo  = (k >= TO);
        h    = R + k + 1;
        e    = tmo ? R + TO : h + D + 1;
        last = e + 3;
        a    = $urandom_range(1, D);
        src  = pat[0] ? 2'b01 : 2'b10;
        code = pat[0] ? data[7:0] : data[15:8];

        for (int m = 1; m <= last; m++) begin
            @(posedge clk);
            #1;
            fin = (m >= e);
            run = (m >= R) && (m < (tmo ? e : h));
            cap = tmo ? (m >= e) : (m >= h);
            chk("core_rst", 32'(bus.core_rst), 32'((m < R) || fin));
            chk("running", 32'(bus.running), 32'(run));
            chk("done", 32'(bus.done), 32'(fin));
            chk("timeout", 32'(bus.timeout), 32'(tmo && fin));
            chk("exit_code", 32'(bus.exit_code),
                !cap ? 32'h0 : tmo ? 32'hFF : 32'(code));
            chk("exit_src", 32'(bus.exit_src),
                (!cap || tmo) ? 32'h0 : 32'(src));
            if (!(tmo && fin)) begin
                exp_cnt = (m < R) ? 0 : ((m - R) < k ? m - R : k);
                chk("cycle_cnt", bus.cycle_cnt, exp_cnt);
            end
            if (abort && !tmo && m == h + a) begin
                rst_n = 1'b0;
                #1;
                check_reset();
                return;
            end
            #1;
            j = m - R;
            if (m < R || j > k) begin
                bus.halt_req = 2'($urandom);
                bus.halt_data = 16'($urandom);
            end else if (j < k) begin
                bus.halt_req = '0;
                bus.halt_data = 16'($urandom);
            end else begin
                bus.halt_req = pat;
                bus.halt_data = data;
            end
        end
`ifndef SIM_TIMEOUT_EN
        chk("sat_cycle_cnt", 32'(bus_s.cycle_cnt), 32'hF);
        chk("sat_running", 32'(bus_s.running), 1);
`endif
    endtask

    initial begin
        bus.halt_req = '0;
        bus.halt_data = '0;
        bus_s.halt_req = '0;
        bus_s.halt_data = '0;

        run_trial(100, 2'b10, 16'h2A00, 1'b0);
        run_trial(5, 2'b11, 16'h0201, 1'b0);
        run_trial(63, 2'b01, 16'h7733, 1'b0);
        run_trial(0, 2'b10, 16'h5500, 1'b0);
        run_trial(30, 2'b10, 16'h1100, 1'b1);
        for (int t = 0; t < 8; t++) begin
            run_trial(int'($urandom_range(0, 120)),
                      2'($urandom_range(1, 3)),
                      16'($urandom),
                      1'($urandom_range(0, 1)));
        end
        rst_n = 1'b0;
        #1;
        check_reset();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sim_harness_ctrl.md
# sim_harness_ctrl

Simulation-side harness controller that sits between the bench clock/reset and `riscv_top`, replacing the fixed-delay reset and manual `$finish` timing. It sequences core reset for a programmable number of cycles, counts run cycles, and detects program end from any of several halt sources. It also enforces a cycle-budget watchdog and reports a sticky done/timeout status with the exit code, so benches terminate deterministically.

## Interface
Parameters:
- `RST_CYCLES`, 25: clock cycles core reset is held after `rst_n` release (≥1).
- `NUM_SRC`, 2: number of halt request channels (≥1).
- `CNT_W`, 32: width of the run-cycle counter.
- `DRAIN_CYCLES`, 16: cycles allowed after a halt for UART/IO flush before done (≥1).
- `TIMEOUT_CYCLES`, 32'd150_000_000: run-cycle budget; only used when the watchdog is compiled in.

Ports:
- `clk` in 1: sole clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `halt_req` in NUM_SRC: per-source halt request, level-sampled in RUN.
- `halt_data` in 8*NUM_SRC: per-source exit code; source i at bits [8i+7:8i].
- `core_rst` out 1: active-high reset to `riscv_top` (`btnC`).
- `running` out 1: high in RUN only.
- `cycle_cnt` out CNT_W: RUN cycles elapsed.
- `done` out 1: sticky end-of-simulation flag.
- `timeout` out 1: sticky; done was caused by the watchdog.
- `exit_code` out 8: captured exit code.
- `exit_src` out NUM_SRC: one-hot source that halted; zero on timeout.

## Operation
- FSM states: RST, RUN, DRAIN, DONE.
- Async reset (`rst_n`=0): state RST, `core_rst`=1, `running`=0, `cycle_cnt`=0, `done`=0, `timeout`=0, `exit_code`=0, `exit_src`=0, internal reset/drain counters 0.
- RST: reset counter increments each cycle; on the edge where it equals RST_CYCLES-1 → RUN, `core_rst`←0, `running`←1.
- RUN: `cycle_cnt` increments by 1 per cycle, saturating at all-ones (no wrap).
- RUN, any `halt_req` bit high: lowest-index asserted source wins; capture its `halt_data` byte into `exit_code`, its one-hot into `exit_src`; → DRAIN, `running`←0.
- DRAIN: core stays out of reset; drain counter runs DRAIN_CYCLES cycles, then → DONE.
- DONE: `done`←1, `core_rst`←1 (core frozen); absorbing until `rst_n`.
- `halt_req` is ignored in RST, DRAIN and DONE; captured values never change after the RUN→DRAIN edge.
- Watchdog (when compiled in): in RUN, if `cycle_cnt` == TIMEOUT_CYCLES-1 and no `halt_req` → DONE directly (no drain), `timeout`←1, `exit_code`←8'hFF, `exit_src`←0.
- Simultaneous halt and timeout on the same edge: halt wins, `timeout` stays 0.
- `rst_n` asserted mid-operation in any state: immediate return to reset values; full RST sequence repeats on release.

## Timing
- All outputs registered; no combinational input-to-output paths.
- `core_rst` is high for exactly RST_CYCLES rising edges after `rst_n` deasserts.
- `cycle_cnt` reads 0 in the first RUN cycle; value after halt edge = number of RUN cycles before the halt cycle, then frozen.
- Halt to `done`: DRAIN_CYCLES+1 cycles from the edge sampling `halt_req`.
- Timeout to `done`: 1 cycle.

## Configuration
- `SIM_TIMEOUT_EN` defined: watchdog active as described; `TIMEOUT_CYCLES` used.
- Not defined: no watchdog logic; `timeout` tied 0; RUN exits only by halt; `cycle_cnt` saturates.

## Test plan
- Reset sequencing: RST_CYCLES=25, release `rst_n` at t0 -> `core_rst` high 25 edges then 0, `running`=1, `cycle_cnt`=0.
- Single halt: `halt_req`=2'b10, `halt_data`[15:8]=8'h2A at RUN cycle 100 -> `exit_src`=2'b10, `exit_code`=8'h2A, `cycle_cnt`=100 frozen, `done`=1 after 17 cycles, `core_rst`=1.
- Priority: `halt_req`=2'b11, codes 8'h01/8'h02 -> `exit_src`=2'b01, `exit_code`=8'h01; later `halt_req` changes have no effect.
- Watchdog (SIM_TIMEOUT_EN, TIMEOUT_CYCLES=64, no halts) -> `done`=1, `timeout`=1, `exit_code`=8'hFF, `exit_src`=0 at run cycle 64; halt on that exact cycle -> halt path, `timeout`=0.
- Mid-run reset: drop `rst_n` during DRAIN -> all outputs at reset values immediately; re-release gives full 25-cycle RST then RUN.
- Saturation (CNT_W=4, macro off, no halt) -> `cycle_cnt` holds 4'hF, stays in RUN.
